// File: rtl/tff_toggle_sequencer_pkg.sv
// Shared definitions for the T flip-flop toggle sequencer: state encodings and default sizes.
package tff_toggle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/tff_toggle_sequencer_tff_cell.sv
// Single T flip-flop cell with synchronous reset and a synchronous bank-clear input.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_toggle_sequencer.sv
// Command-driven sequencer for a bank of WIDTH T flip-flops.
// Optional macro TFF_SEQ_PAUSE_EN adds a pause input that stalls the RUN state.
module tff_toggle_sequencer
  import tff_toggle_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_clear,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef TFF_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] t;
  logic             advance;
  logic             accept;
  logic             clr;

`ifdef TFF_SEQ_PAUSE_EN
  assign advance = ~pause;
`else
  assign advance = 1'b1;
`endif

  assign accept = cmd_valid && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_clear) begin
            state_nxt = ST_CLEAR;
          end else if (cmd_count == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      // Leaving on remaining==1 makes exactly count toggles happen.
      ST_RUN:   if (advance && (remaining == CNT_W'(1))) state_nxt = ST_DONE;
      ST_CLEAR: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    clr       = (state == ST_CLEAR);
    t         = '0;
    if ((state == ST_RUN) && advance) begin
      t = mask_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      mask_r    <= '0;
    end else if (accept) begin
      mask_r    <= cmd_mask;
      remaining <= cmd_clear ? '0 : cmd_count;
    end else if ((state == ST_RUN) && advance) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .t   (t[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_tff_toggle_sequencer.sv
// Directed self-checking bench for tff_toggle_sequencer (WIDTH=4, CNT_W=8); covers TFF_SEQ_PAUSE_EN when defined.
module tb_tff_toggle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_clear = 1'b0;
  logic [3:0] cmd_mask = 4'b0000;
  logic [7:0] cmd_count = 8'd0;
  logic [3:0] q;
  logic       busy;
  logic       done;
`ifdef TFF_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int busy_cnt;
  int done_cnt;

  tff_toggle_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
`ifdef TFF_SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic clear, input logic [3:0] mask, input logic [7:0] count);
    cmd_valid = 1'b1;
    cmd_clear = clear;
    cmd_mask  = mask;
    cmd_count = count;
    tick();
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
  endtask

  initial begin
    // Test 1: reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);

    // Test 2: mask=0101 count=3
    issue(1'b0, 4'b0101, 8'd3);
    check("t2_e0_q", 32'(q), 32'h0);
    check("t2_e0_busy", 32'(busy), 32'h1);
    check("t2_e0_ready", 32'(cmd_ready), 32'h0);
    tick();
    check("t2_e1_q", 32'(q), 32'h5);
    tick();
    check("t2_e2_q", 32'(q), 32'h0);
    check("t2_e2_done", 32'(done), 32'h0);
    tick();
    check("t2_e3_q", 32'(q), 32'h5);
    check("t2_e3_done", 32'(done), 32'h1);
    tick();
    check("t2_e4_done", 32'(done), 32'h0);
    check("t2_e4_ready", 32'(cmd_ready), 32'h1);
    check("t2_e4_q", 32'(q), 32'h5);

    // Test 3: count=0
    issue(1'b0, 4'b1111, 8'd0);
    check("t3_e0_done", 32'(done), 32'h1);
    check("t3_e0_q", 32'(q), 32'h5);
    tick();
    check("t3_e1_done", 32'(done), 32'h0);
    check("t3_e1_ready", 32'(cmd_ready), 32'h1);
    check("t3_e1_q", 32'(q), 32'h5);

    // Test 4: mask=1111 count=4, busy for 5 cycles
    busy_cnt = 0;
    done_cnt = 0;
    issue(1'b0, 4'b1111, 8'd4);
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i < 5) tick();
    end
    check("t4_busy_cycles", 32'(busy_cnt), 32'd5);
    check("t4_done_pulses", 32'(done_cnt), 32'd1);
    check("t4_q", 32'(q), 32'h5);

    // Reach q=0110 with a single toggle of 0011
    issue(1'b0, 4'b0011, 8'd1);
    tick();
    check("pre5_q", 32'(q), 32'h6);
    check("pre5_done", 32'(done), 32'h1);
    tick();

    // Test 5: clear wins over mask/count
    issue(1'b1, 4'b1111, 8'd9);
    check("t5_e0_q", 32'(q), 32'h6);
    check("t5_e0_done", 32'(done), 32'h0);
    tick();
    check("t5_e1_q", 32'(q), 32'h0);
    check("t5_e1_done", 32'(done), 32'h1);
    tick();
    check("t5_e2_ready", 32'(cmd_ready), 32'h1);
    check("t5_e2_q", 32'(q), 32'h0);

    // Test 6: reset after 2 of 5 toggles
    issue(1'b0, 4'b0011, 8'd5);
    tick();
    check("t6_e1_q", 32'(q), 32'h3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_q", 32'(q), 32'h0);
    check("t6_rst_ready", 32'(cmd_ready), 32'h1);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("t6_no_done", 32'(done_cnt), 32'd0);
    check("t6_q_hold", 32'(q), 32'h0);

    // Full-range count 255 with mask 0001; a clear request while busy is ignored
    done_cnt = 0;
    issue(1'b0, 4'b0001, 8'd255);
    tick();
    check("max_e1_q", 32'(q), 32'h1);
    cmd_valid = 1'b1;
    cmd_clear = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    check("max_busy_ignore_q", 32'(q), 32'h0);
    for (int i = 3; i <= 255; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("max_e255_done", 32'(done), 32'h1);
    check("max_e255_q", 32'(q), 32'h1);
    check("max_early_done", 32'(done_cnt), 32'd0);
    tick();
    check("max_idle", 32'(cmd_ready), 32'h1);

    // mask=0 with count=2: full run, no change
    busy_cnt = 0;
    issue(1'b0, 4'b0000, 8'd2);
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_cnt++;
      if (i == 2) check("m0_done", 32'(done), 32'h1);
      tick();
    end
    check("m0_busy_cycles", 32'(busy_cnt), 32'd3);
    check("m0_q", 32'(q), 32'h1);
    check("m0_ready", 32'(cmd_ready), 32'h1);

`ifdef TFF_SEQ_PAUSE_EN
    // Pause for two RUN cycles: same final q, done two cycles later
    issue(1'b0, 4'b0101, 8'd3);
    pause = 1'b1;
    tick();
    check("p_e1_q", 32'(q), 32'h1);
    tick();
    check("p_e2_q", 32'(q), 32'h1);
    pause = 1'b0;
    tick();
    check("p_e3_q", 32'(q), 32'h4);
    tick();
    check("p_e4_q", 32'(q), 32'h1);
    check("p_e4_done", 32'(done), 32'h0);
    tick();
    check("p_e5_q", 32'(q), 32'h4);
    check("p_e5_done", 32'(done), 32'h1);
    tick();
    check("p_e6_ready", 32'(cmd_ready), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
